iic_slave_eeprom: RTL and testbench

- I2C target (responder) emulating a 256-byte serial EEPROM in fabric.
- Answers the same byte-write, page-write, random-read and sequential-read transactions that the parameter controller issues as I2C initiator.
- Lets the controller and its bench run against synthesizable RTL instead of a vendor behavioural model.
- Oversamples SCL/SDA on the system clock; drives SDA open-drain (low or released only).

---
 rtl/iic_slave_eeprom.sv | 272 +++++++++++++++++++++++++++
 tb/tb_iic_slave_eeprom.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_eeprom.sv
// ---------------------------------------------------------------------------
// iic_slave_eeprom
// I2C target that emulates a 256-byte serial EEPROM held in fabric registers.
// It supports byte write, page write, random read and sequential read.
// SCL and SDA are oversampled on clk. SDA is driven open-drain: the block
// either pulls the line low or releases it.
//
// Ports
//   clk         system clock, at least 20x the SCL frequency
//   rst         asynchronous active-high reset
//   iic_clk     SCL from the initiator
//   iic_sda_in  resolved SDA line level
//   iic_sda_oe  1 = pull SDA low, 0 = release
//   busy        high from an address-matched START to the following STOP
//   wr_pulse    one-clk pulse per byte committed to memory
//   wr_addr_o   address of the committed byte, valid with wr_pulse
//   wr_data_o   data of the committed byte, valid with wr_pulse
// ---------------------------------------------------------------------------
module iic_slave_eeprom #(
    parameter logic [6:0]  DEV_ADDR  = 7'b1010000,
    parameter int unsigned PAGE_SIZE = 16,
    parameter logic [7:0]  INIT_VAL  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iic_clk,
    input  logic       iic_sda_in,
    output logic       iic_sda_oe,
    output logic       busy,
    output logic       wr_pulse,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o
);

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] BITS_PER_BYTE = CNT_W'(8);
    // Low pointer bits that advance during a page write; upper bits stay fixed
    localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEVA,
        ST_ACK1,
        ST_WADDR,
        ST_ACK2,
        ST_WDAT,
        ST_ACK3,
        ST_RDAT,
        ST_RACK,
        ST_IGNORE
    } state_t;

    // Synchronizer and edge-history flops
    logic scl_meta, scl_sync, scl_prev;
    logic sda_meta, sda_sync, sda_prev;

    // Bus events derived from synchronized levels
    logic scl_rise, scl_fall, start_det, stop_det;

    // FSM state and datapath registers
    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       ptr, ptr_n;
    logic             rw, rw_n;
    logic             ack_bit, ack_bit_n;
    logic             sda_oe_n, busy_n, wr_pulse_n;
    logic [7:0]       wr_addr_n, wr_data_n;
    logic             mem_we;

    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] mem_rd;

    // Two-flop synchronizers. They reset to the idle (high) bus level, so
    // leaving reset on an idle bus does not create a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= iic_clk;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= iic_sda_in;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    // START is an SDA fall while SCL is high; STOP is an SDA rise while SCL is high
    assign scl_rise  =  scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync &  scl_prev;
    assign start_det =  scl_sync &  scl_prev &  sda_prev & ~sda_sync;
    assign stop_det  =  scl_sync &  scl_prev & ~sda_prev &  sda_sync;

    // Combinational read port, feeding the shift-register load
    assign mem_rd = mem[ptr];

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            ack_bit    <= 1'b1;
            iic_sda_oe <= 1'b0;
            busy       <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            ack_bit    <= ack_bit_n;
            iic_sda_oe <= sda_oe_n;
            busy       <= busy_n;
            wr_pulse   <= wr_pulse_n;
            wr_addr_o  <= wr_addr_n;
            wr_data_o  <= wr_data_n;
        end
    end

    // Memory array; reset restores every byte to INIT_VAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else if (mem_we) begin
            mem[ptr] <= shreg;
        end
    end

    // Next-state and output logic. SDA changes are always made on a detected
    // SCL fall, so the registered output moves one clk after that fall.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        ptr_n      = ptr;
        rw_n       = rw;
        ack_bit_n  = ack_bit;
        sda_oe_n   = iic_sda_oe;
        busy_n     = busy;
        wr_pulse_n = 1'b0;
        wr_addr_n  = wr_addr_o;
        wr_data_n  = wr_data_o;
        mem_we     = 1'b0;

        if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ST_DEVA;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                // Receive states shift MSB first on SCL rise and act on the
                // SCL fall that ends the eighth bit.
                ST_DEVA, ST_WADDR, ST_WDAT: begin
                    if (scl_rise && bit_cnt != BITS_PER_BYTE) begin
                        shreg_n   = {shreg[6:0], sda_sync};
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
                        bit_cnt_n = '0;
                        if (state == ST_DEVA) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                state_n  = ST_ACK1;
                                rw_n     = shreg[0];
                                busy_n   = 1'b1;
                                sda_oe_n = 1'b1;
                            end else begin
                                state_n  = ST_IGNORE;
                            end
                        end else if (state == ST_WADDR) begin
                            ptr_n    = shreg;
                            state_n  = ST_ACK2;
                            sda_oe_n = 1'b1;
                        end else begin
                            // Commit and advance within the current page only
                            mem_we     = 1'b1;
                            wr_pulse_n = 1'b1;
                            wr_addr_n  = ptr;
                            wr_data_n  = shreg;
                            ptr_n      = (ptr & ~PAGE_MASK) | ((ptr + 8'd1) & PAGE_MASK);
                            state_n    = ST_ACK3;
                            sda_oe_n   = 1'b1;
                        end
                    end
                end

                ST_ACK1: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            state_n  = ST_RDAT;
                            shreg_n  = mem_rd;
                            sda_oe_n = ~mem_rd[7];
                        end else begin
                            state_n  = ST_WADDR;
                            sda_oe_n = 1'b0;
                        end
                    end
                end

                ST_ACK2, ST_ACK3: begin
                    if (scl_fall) begin
                        state_n   = ST_WDAT;
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b0;
                    end
                end

                // The current bit sits on shreg[7]; each fall after a rise
                // presents the next one.
                ST_RDAT: begin
                    if (scl_rise && bit_cnt != BITS_PER_BYTE) begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end else if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b0;
                        ptr_n     = ptr + 8'd1;
                        state_n   = ST_RACK;
                    end else if (scl_fall && bit_cnt != '0) begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end
                end

                // Initiator's acknowledge is sampled on the rise, acted on at the fall
                ST_RACK: begin
                    if (scl_rise) begin
                        ack_bit_n = sda_sync;
                    end else if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (!ack_bit) begin
                            state_n  = ST_RDAT;
                            shreg_n  = mem_rd;
                            sda_oe_n = ~mem_rd[7];
                        end else begin
                            state_n  = ST_IGNORE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                    sda_oe_n = 1'b0;
                end

                default: begin
                    state_n  = ST_IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_slave_eeprom.sv
// ---------------------------------------------------------------------------
// tb_iic_slave_eeprom
// Bit-banged I2C initiator driving iic_slave_eeprom. The bench keeps a
// transaction-level reference model of the memory and the address pointer,
// runs directed scenarios followed by randomized transfers, and compares
// read data, ACKs, busy and committed writes against that model.
// ---------------------------------------------------------------------------
module tb_iic_slave_eeprom;

    localparam logic [6:0] DEV = 7'b1010000;
    localparam int         PS  = 16;
    localparam int         Q   = 6;     // clks per quarter SCL period

    logic       clk;
    logic       rst;
    logic       scl;
    logic       sda_drv;
    logic       sda_bus;
    logic       iic_sda_oe;
    logic       busy;
    logic       wr_pulse;
    logic [7:0] wr_addr_o;
    logic [7:0] wr_data_o;

    // Open-drain bus: low if either side pulls it down
    assign sda_bus = sda_drv & ~iic_sda_oe;

    iic_slave_eeprom #(
        .DEV_ADDR  (DEV),
        .PAGE_SIZE (PS),
        .INIT_VAL  (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iic_clk    (scl),
        .iic_sda_in (sda_bus),
        .iic_sda_oe (iic_sda_oe),
        .busy       (busy),
        .wr_pulse   (wr_pulse),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [7:0]  mem_m [256];
    int          ptr_m;
    logic [15:0] exp_wr [$];
    logic [15:0] wr_q   [$];
    logic [7:0]  wbuf   [4];

    // Capture every committed byte as {addr, data}
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) wr_q.push_back({wr_addr_o, wr_data_o});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
        ptr_m = 0;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl     = 1'b1; wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl     = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl     = 1'b1; wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    // One SCL period; samples the bus and the target's drive mid-high
    task automatic i2c_bit(input logic b, output logic r, output logic oe);
        sda_drv = b;    wait_clk(Q);
        scl     = 1'b1; wait_clk(Q);
        r  = sda_bus;
        oe = iic_sda_oe;
        wait_clk(Q);
        scl     = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic oe_ack);
        logic r, oe;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r, oe);
        i2c_bit(1'b1, r, oe);
        ack    = ~r;
        oe_ack = oe;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b, output logic oe_ack);
        logic r, oe;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r, oe);
            b[i] = r;
        end
        i2c_bit(nack, r, oe);
        oe_ack = oe;
    endtask

    task automatic check_commits(input string tag);
        chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            chk({tag, "_wr_entry"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    endtask

    // Write n bytes from wbuf starting at addr (n = 0 only sets the pointer)
    task automatic tx_write(input logic [7:0] addr, input int n);
        logic ack, oe;
        int   base, a;
        wr_q.delete();
        exp_wr.delete();
        i2c_start();
        send_byte({DEV, 1'b0}, ack, oe);
        chk("wr_dev_ack", 32'(ack), 32'd1);
        chk("wr_busy", 32'(busy), 32'd1);
        send_byte(addr, ack, oe);
        chk("wr_addr_ack", 32'(ack), 32'd1);
        base = int'(addr) - int'(addr) % PS;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack, oe);
            chk("wr_data_ack", 32'(ack), 32'd1);
            a = base + (int'(addr) % PS + i) % PS;
            mem_m[a] = wbuf[i];
            exp_wr.push_back({8'(a), wbuf[i]});
        end
        i2c_stop();
        wait_clk(4);
        chk("wr_busy_clr", 32'(busy), 32'd0);
        ptr_m = base + (int'(addr) % PS + n) % PS;
        check_commits("wr");
    endtask

    // Read n bytes, from addr when use_addr is set, else from the current pointer
    task automatic tx_read(input logic use_addr, input logic [7:0] addr, input int n);
        logic       ack, oe;
        logic [7:0] b;
        wr_q.delete();
        i2c_start();
        if (use_addr) begin
            send_byte({DEV, 1'b0}, ack, oe);
            chk("rd_dev0_ack", 32'(ack), 32'd1);
            send_byte(addr, ack, oe);
            chk("rd_addr_ack", 32'(ack), 32'd1);
            ptr_m = int'(addr);
            i2c_start();
        end
        send_byte({DEV, 1'b1}, ack, oe);
        chk("rd_dev1_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b, oe);
            chk("rd_data", 32'(b), 32'(mem_m[ptr_m]));
            chk("rd_mack_release", 32'(oe), 32'd0);
            ptr_m = (ptr_m + 1) % 256;
        end
        i2c_stop();
        wait_clk(4);
        chk("rd_busy_clr", 32'(busy), 32'd0);
        chk("rd_no_commit", 32'(wr_q.size()), 32'd0);
    endtask

    // Address, then k (<8) data bits, then STOP: nothing may be committed
    task automatic tx_abort(input logic [7:0] addr, input int k);
        logic ack, oe, r;
        wr_q.delete();
        i2c_start();
        send_byte({DEV, 1'b0}, ack, oe);
        chk("ab_dev_ack", 32'(ack), 32'd1);
        send_byte(addr, ack, oe);
        chk("ab_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < k; i++) i2c_bit(1'($urandom), r, oe);
        i2c_stop();
        wait_clk(4);
        chk("ab_no_commit", 32'(wr_q.size()), 32'd0);
        chk("ab_busy_clr", 32'(busy), 32'd0);
        ptr_m = int'(addr);
    endtask

    initial begin
        logic ack, oe;
        int   op, n;

        rst     = 1'b1;
        scl     = 1'b1;
        sda_drv = 1'b1;
        model_reset();
        wait_clk(5);
        chk("rst_oe", 32'(iic_sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Byte write then random read of the same location
        wbuf[0] = 8'h3C;
        tx_write(8'h05, 1);
        tx_read(1'b1, 8'h05, 1);

        // Sequential read across 0xFF -> 0x00 via a pointer-only write
        tx_write(8'hFE, 0);
        tx_read(1'b0, 8'h00, 3);

        // Page write wrapping 0x0F -> 0x00, then 0x10 untouched
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        tx_write(8'h0E, 3);
        tx_read(1'b1, 8'h10, 1);
        tx_read(1'b1, 8'h0E, 3);

        // Address mismatch is ignored; a following valid address is ACKed
        i2c_start();
        send_byte(8'hB0, ack, oe);
        chk("nomatch_ack", 32'(ack), 32'd0);
        chk("nomatch_oe", 32'(oe), 32'd0);
        chk("nomatch_busy", 32'(busy), 32'd0);
        i2c_start();
        send_byte({DEV, 1'b0}, ack, oe);
        chk("rematch_ack", 32'(ack), 32'd1);
        send_byte(8'h20, ack, oe);
        chk("rematch_addr_ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_clk(4);
        ptr_m = 32'h20;
        chk("rematch_busy_clr", 32'(busy), 32'd0);

        // Partial data byte aborted by STOP; memory keeps 0x3C
        tx_abort(8'h05, 4);
        tx_read(1'b0, 8'h00, 1);

        // Reset while the target drives read data
        i2c_start();
        send_byte({DEV, 1'b0}, ack, oe);
        send_byte(8'h05, ack, oe);
        i2c_start();
        send_byte({DEV, 1'b1}, ack, oe);
        chk("rdat_drive_msb", 32'(iic_sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_oe", 32'(iic_sda_oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        sda_drv = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        scl = 1'b1;
        wait_clk(Q);
        tx_read(1'b1, 8'h05, 1);

        // Randomized transfers against the model
        for (int it = 0; it < 16; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    n = int'($urandom_range(0, 4));
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    tx_write(8'($urandom), n);
                end
                1: tx_read(1'b1, 8'($urandom), int'($urandom_range(1, 4)));
                2: tx_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
                default: tx_abort(8'($urandom), int'($urandom_range(1, 7)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
